vram_blit_ctrl: RTL and testbench
=================================

Name: vram_blit_ctrl

Overview:
- Sequences bulk operations on port B of the text-mode VRAM (2 glyph cells per 32-bit word, 40 words per text row, 30 rows).
- Bulk operations: clear screen, scroll up one row, fill one row.
- Arbitrates port B between the Avalon CPU path (fixed priority) and the internal blit engine.
- Sits between the Avalon slave decode and the dual-port VRAM, in front of the text-mode display interface.

Parameters:
- ROW_WORDS, 40, 32-bit words per text row.
- NUM_ROWS, 30, text rows.
- ADDR_W, 11, VRAM word-address width; must satisfy 2^ADDR_W >= ROW_WORDS*NUM_ROWS.

Ports:
- CLK  in  1  system clock (50 MHz).
- RESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  0=NOP, 1=CLEAR, 2=SCROLL, 3=FILL_ROW.
- cmd_row  in  5  target row for FILL_ROW.
- fill_data  in  32  fill word for CLEAR/FILL_ROW and for the SCROLL bottom row.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- cpu_cs, cpu_read, cpu_write  in  1 each  Avalon strobes, already decoded to VRAM space.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_byte_en  in  4  CPU byte enables.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  equals ram_q (combinational passthrough).
- ram_addr  out  ADDR_W  to VRAM address_b.
- ram_byte_en  out  4  to VRAM byteena_b.
- ram_wdata  out  32  to VRAM data_b.
- ram_rden, ram_wren  out  1 each  to VRAM rden_b / wren_b.
- ram_q  in  32  from VRAM q_b; one-cycle registered read latency.
- vs  in  1  VGA vertical sync (active low); used only with the optional feature.

Behaviour:
- Reset: state IDLE; cmd_ready=1; busy=0; done=0; engine counters=0; no RAM strobes driven by the engine.
- Reset mid-operation aborts the command immediately. No further engine writes occur and no done pulse is issued.

Arbitration:
- cpu_act = cpu_cs & (cpu_read | cpu_write).
- When cpu_act=1, the CPU owns port B that cycle: ram_* = cpu_*, with ram_rden = cpu_read and ram_wren = cpu_write.
- When cpu_act=0, the engine drives port B.
- An engine grant is lost for a full cycle; the engine holds its state and retries the next cycle.

Command handshake:
- A command is accepted when cmd_valid & cmd_ready.
- cmd_op, cmd_row and fill_data are registered on acceptance.
- cmd_ready = (state==IDLE); busy = ~cmd_ready.
- NOP, or FILL_ROW with cmd_row >= NUM_ROWS, performs no writes and pulses done one cycle after acceptance.

FSM states: IDLE, (SYNC), READ, CAPT, WRITE, FILL, DONE.

CLEAR:
- FILL writes fill_data with byte_en 4'hF to addresses 0 .. ROW_WORDS*NUM_ROWS-1, one write per granted cycle.
- After the last write, go to DONE.

FILL_ROW:
- FILL over addresses cmd_row*ROW_WORDS .. +ROW_WORDS-1.

SCROLL:
- For dst = 0 .. ROW_WORDS*(NUM_ROWS-1)-1, loop through three states:
  - READ: on a granted cycle, issue rden at dst+ROW_WORDS.
  - CAPT: unconditionally latch ram_q the cycle after the granted read. CPU activity in CAPT is permitted; q_b is still valid.
  - WRITE: on a granted cycle, write the latched word to dst.
- Then FILL the bottom row with fill_data.

DONE:
- done=1 for exactly one cycle, then IDLE.

Latency with no CPU contention:
- CLEAR: 1200 write cycles, then done.
- SCROLL: 1160*3 + 40 = 3520 cycles, then done.
- Each CPU-active cycle that blocks a READ, WRITE or FILL adds one cycle.

Other rules:
- CPU writes to VRAM while busy=1 are performed, but their ordering against engine writes is undefined; software must not write VRAM while busy.
- Address counters are ADDR_W bits and never wrap within a command. The terminal compare is on exact last address.

Optional Feature:
- Macro: VRAM_BLIT_VSYNC_ALIGN_EN.
- When defined:
  - An accepted command enters SYNC and waits for a falling edge of vs (vs registered twice into the CLK domain) before its first RAM access.
  - busy=1 throughout SYNC.
  - Reset in SYNC returns to IDLE.
- When undefined: SYNC does not exist; the first access is the cycle after acceptance and the vs port is ignored.

Decomposition:
- Package vram_blit_pkg holds:
  - enum blit_op_e {NOP, CLEAR, SCROLL, FILL_ROW};
  - enum blit_state_e;
  - constants ROW_WORDS_DEF=40, NUM_ROWS_DEF=30, VRAM_WORDS_DEF=1200.
- Sub-module vram_blit_addr_ctr: loadable, enable-gated ADDR_W counter with start/end load and a last-address flag. It is used for dst; src is derived as dst+ROW_WORDS.

Test Plan:
- Reset, then CLEAR with fill_data=32'h00200020 and CPU idle -> 1200 writes of 32'h00200020 to addresses 0..1199; done pulses at cycle 1201 after acceptance; busy low afterwards.
- Preload word k = k; SCROLL with fill_data=0 -> word k = k+40 for k<1160; words 1160..1199 = 0; done after 3520 cycles.
- FILL_ROW row=29 with fill 32'hDEADBEEF while the CPU reads address 5 every other cycle -> words 1160..1199 = DEADBEEF; cpu_rdata returns word 5 one cycle after each read; done after 80 cycles.
- FILL_ROW row=31 -> no ram_wren from the engine; done exactly one cycle after acceptance.
- Assert RESET for 1 cycle 100 cycles into CLEAR -> busy=0 and done=0 next cycle; words >= 100 are unchanged.
- With VRAM_BLIT_VSYNC_ALIGN_EN: CLEAR accepted while vs=1 -> no engine write until 3 cycles after vs falls.

Source files
------------

// File: rtl/vram_blit_pkg.sv
// Shared types and default geometry for the text-mode VRAM blit controller.
package vram_blit_pkg;

  localparam int unsigned ROW_WORDS_DEF  = 40;
  localparam int unsigned NUM_ROWS_DEF   = 30;
  localparam int unsigned VRAM_WORDS_DEF = ROW_WORDS_DEF * NUM_ROWS_DEF;

  typedef enum logic [1:0] {
    NOP      = 2'd0,
    CLEAR    = 2'd1,
    SCROLL   = 2'd2,
    FILL_ROW = 2'd3
  } blit_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StRead,
    StCapt,
    StWrite,
    StFill,
    StDone
  } blit_state_e;

  function automatic int unsigned row_base(input int unsigned row, input int unsigned row_words);
    return row * row_words;
  endfunction

endpackage

// File: rtl/vram_blit_ctrl_if.sv
// Command, CPU and VRAM port-B signals of the blit controller; slave is the controller's view.
interface vram_blit_ctrl_if
  import vram_blit_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
);
  logic              cmd_valid;
  logic              cmd_ready;
  blit_op_e          cmd_op;
  logic [4:0]        cmd_row;
  logic [31:0]       fill_data;
  logic              busy;
  logic              done;

  logic              cpu_cs;
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_byte_en;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_byte_en;
  logic [31:0]       ram_wdata;
  logic              ram_rden;
  logic              ram_wren;
  logic [31:0]       ram_q;

  logic              vs;

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, fill_data,
    input  cpu_cs, cpu_read, cpu_write, cpu_addr, cpu_byte_en, cpu_wdata,
    input  ram_q, vs,
    output cmd_ready, busy, done, cpu_rdata,
    output ram_addr, ram_byte_en, ram_wdata, ram_rden, ram_wren
  );

  modport master (
    output cmd_valid, cmd_op, cmd_row, fill_data,
    output cpu_cs, cpu_read, cpu_write, cpu_addr, cpu_byte_en, cpu_wdata,
    output ram_q, vs,
    input  cmd_ready, busy, done, cpu_rdata,
    input  ram_addr, ram_byte_en, ram_wdata, ram_rden, ram_wren
  );

endinterface

// File: rtl/vram_blit_addr_ctr.sv
// Loadable word-address counter with a registered end address and exact last-address flag.
module vram_blit_addr_ctr #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] end_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] end_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      end_q  <= '0;
    end else if (load_i) begin
      addr_q <= start_i;
      end_q  <= end_i;
    end else if (en_i) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == end_q);

endmodule

// File: rtl/vram_blit_ctrl.sv
// VRAM port-B blit engine (clear / scroll / fill row) with CPU-priority arbitration.
// Optional VRAM_BLIT_VSYNC_ALIGN_EN delays each command's first access to a vs falling edge.
module vram_blit_ctrl
  import vram_blit_pkg::*;
#(
  parameter int unsigned ROW_WORDS = ROW_WORDS_DEF,
  parameter int unsigned NUM_ROWS  = NUM_ROWS_DEF,
  parameter int unsigned ADDR_W    = 11
) (
  input logic             CLK,
  input logic             RESET,
  vram_blit_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(ROW_WORDS * NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] BotRow     = ADDR_W'(ROW_WORDS * (NUM_ROWS - 1));
  localparam logic [ADDR_W-1:0] ScrollLast = ADDR_W'(ROW_WORDS * (NUM_ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] RowStep    = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] RowLast    = ADDR_W'(ROW_WORDS - 1);

  blit_state_e       state_q, state_d, work_st;
  logic              done_q, ready_q;
  logic [31:0]       fill_q, fill_d, capt_q, capt_d;
  logic              accept, row_ok;
  logic [ADDR_W-1:0] row_start, acc_start, acc_end;
  logic              ctr_load, ctr_en, dst_last;
  logic [ADDR_W-1:0] ctr_start, ctr_end, dst;
  logic              cpu_act, eng_grant;
  logic              eng_rden, eng_wren;
  logic [ADDR_W-1:0] eng_addr;
  logic [31:0]       eng_wdata;

`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
  logic [2:0]  vs_sync_q;
  logic        vs_fall;
  blit_state_e first_q, first_d;
  assign vs_fall = vs_sync_q[2] & ~vs_sync_q[1];
`else
  logic unused_vs;
  assign unused_vs = bus.vs;
`endif

  assign accept    = bus.cmd_valid & ready_q;
  assign row_ok    = 32'(bus.cmd_row) < NUM_ROWS;
  assign row_start = ADDR_W'(row_base(32'(bus.cmd_row), ROW_WORDS));
  assign cpu_act   = bus.cpu_cs & (bus.cpu_read | bus.cpu_write);
  assign eng_grant = ~cpu_act;

  // Decode an incoming command into its first working state and dst range.
  always_comb begin
    work_st   = StDone;
    acc_start = '0;
    acc_end   = LastAddr;
    unique case (bus.cmd_op)
      CLEAR:  work_st = StFill;
      SCROLL: begin
        work_st = StRead;
        acc_end = ScrollLast;
      end
      FILL_ROW: begin
        if (row_ok) begin
          work_st   = StFill;
          acc_start = row_start;
          acc_end   = row_start + RowLast;
        end
      end
      default: work_st = StDone;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    capt_d    = capt_q;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    ctr_start = acc_start;
    ctr_end   = acc_end;
    eng_rden  = 1'b0;
    eng_wren  = 1'b0;
    eng_addr  = dst;
    eng_wdata = fill_q;
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
    first_d   = first_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          fill_d = bus.fill_data;
          if (work_st == StDone) begin
            state_d = StDone;
          end else begin
            ctr_load = 1'b1;
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
            first_d = work_st;
            state_d = StSync;
`else
            state_d = work_st;
`endif
          end
        end
      end
      StSync: begin
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
        if (vs_fall) state_d = first_q;
`else
        state_d = StIdle;
`endif
      end
      StRead: begin
        eng_rden = 1'b1;
        eng_addr = dst + RowStep;
        if (eng_grant) state_d = StCapt;
      end
      // q_b stays valid under CPU traffic, so the capture never waits for a grant.
      StCapt: begin
        capt_d  = bus.ram_q;
        state_d = StWrite;
      end
      StWrite: begin
        eng_wren  = 1'b1;
        eng_wdata = capt_q;
        if (eng_grant) begin
          if (dst_last) begin
            ctr_load  = 1'b1;
            ctr_start = BotRow;
            ctr_end   = LastAddr;
            state_d   = StFill;
          end else begin
            ctr_en  = 1'b1;
            state_d = StRead;
          end
        end
      end
      StFill: begin
        eng_wren = 1'b1;
        if (eng_grant) begin
          if (dst_last) state_d = StDone;
          else          ctr_en  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      fill_q    <= '0;
      capt_q    <= '0;
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
      vs_sync_q <= 3'b111;
      first_q   <= StIdle;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= (state_d == StDone);
      ready_q   <= (state_d == StIdle);
      fill_q    <= fill_d;
      capt_q    <= capt_d;
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
      vs_sync_q <= {vs_sync_q[1:0], bus.vs};
      first_q   <= first_d;
`endif
    end
  end

  vram_blit_addr_ctr #(
    .ADDR_W (ADDR_W)
  ) u_dst_ctr (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .load_i  (ctr_load),
    .en_i    (ctr_en),
    .start_i (ctr_start),
    .end_i   (ctr_end),
    .addr_o  (dst),
    .last_o  (dst_last)
  );

  always_comb begin
    if (cpu_act) begin
      bus.ram_addr    = bus.cpu_addr;
      bus.ram_byte_en = bus.cpu_byte_en;
      bus.ram_wdata   = bus.cpu_wdata;
      bus.ram_rden    = bus.cpu_read;
      bus.ram_wren    = bus.cpu_write;
    end else begin
      bus.ram_addr    = eng_addr;
      bus.ram_byte_en = 4'hF;
      bus.ram_wdata   = eng_wdata;
      bus.ram_rden    = eng_rden;
      bus.ram_wren    = eng_wren;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = ~ready_q;
  assign bus.done      = done_q;
  assign bus.cpu_rdata = bus.ram_q;

endmodule

// File: tb/tb_vram_blit_ctrl.sv
// Directed bench for vram_blit_ctrl: behavioural dual-port RAM on port B plus hand-computed checks.
module tb_vram_blit_ctrl;
  import vram_blit_pkg::*;

  localparam int unsigned AW = 11;
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  always #10 CLK = ~CLK;

  vram_blit_ctrl_if #(.ADDR_W(AW)) bus ();

  vram_blit_ctrl #(
    .ROW_WORDS (40),
    .NUM_ROWS  (30),
    .ADDR_W    (AW)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc;
  int first_wr;
  int wr0;
  int eng_wr = 0;
  logic [31:0] mem [0:2047];

  // Port-B RAM with one-cycle registered read.
  always @(posedge CLK) begin
    if (bus.ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_byte_en[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    if (bus.ram_rden) bus.ram_q <= mem[bus.ram_addr];
    if (bus.ram_wren && !(bus.cpu_cs && (bus.cpu_read || bus.cpu_write))) eng_wr <= eng_wr + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cpu_idle();
    bus.cpu_cs    = 1'b0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  task automatic preload(input logic [31:0] base);
    for (int k = 0; k < 1200; k++) begin
      @(negedge CLK);
      bus.cpu_cs      = 1'b1;
      bus.cpu_write   = 1'b1;
      bus.cpu_addr    = AW'(k);
      bus.cpu_byte_en = 4'hF;
      bus.cpu_wdata   = base | 32'(k);
    end
    @(negedge CLK);
    cpu_idle();
  endtask

  // Leaves the command on the bus at the negedge before the accepting edge (cycle 0).
  task automatic issue(input blit_op_e op, input logic [4:0] row, input logic [31:0] fd,
                       input bit poll);
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
    @(negedge CLK);
    bus.vs = 1'b1;
    repeat (3) @(negedge CLK);
`endif
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_row   = row;
    bus.fill_data = fd;
`ifdef VRAM_BLIT_VSYNC_ALIGN_EN
    bus.vs = 1'b0;
`endif
    if (poll) begin
      bus.cpu_cs      = 1'b1;
      bus.cpu_read    = 1'b1;
      bus.cpu_addr    = AW'(5);
      bus.cpu_byte_en = 4'hF;
    end
    first_wr = -1;
    cyc      = 0;
    wr0      = eng_wr;
  endtask

  task automatic wait_done(input bit poll, input logic [31:0] poll_exp, input int budget);
    do begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) bus.cmd_valid = 1'b0;
      if (first_wr < 0 && bus.ram_wren && !(bus.cpu_cs && (bus.cpu_read || bus.cpu_write)))
        first_wr = cyc;
      if (poll) begin
        if (bus.cpu_read) check_eq("cpu_rd5", bus.cpu_rdata, poll_exp);
        bus.cpu_read = ~bus.cpu_read;
        bus.cpu_cs   = bus.cpu_read;
      end
    end while (!bus.done && cyc < budget);
    cpu_idle();
    check_eq("done_seen", 32'(bus.done), 1);
    @(negedge CLK);
    check_eq("done_pulse", 32'(bus.done), 0);
    check_eq("ready_after", 32'(bus.cmd_ready), 1);
    check_eq("busy_after", 32'(bus.busy), 0);
  endtask

  initial begin
    int nbad;
    int wr_seen;
    bit seen_done;
    RESET         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.cmd_row   = '0;
    bus.fill_data = '0;
    bus.cpu_addr  = '0;
    bus.cpu_byte_en = 4'hF;
    bus.cpu_wdata = '0;
    bus.vs        = 1'b1;
    cpu_idle();
    repeat (3) @(negedge CLK);
    check_eq("rst_ready", 32'(bus.cmd_ready), 1);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_wren", 32'(bus.ram_wren), 0);
    check_eq("rst_rden", 32'(bus.ram_rden), 0);
    RESET = 1'b0;

    // CLEAR: 1200 writes, done in cycle 1201 after acceptance.
    preload(32'hA500_0000);
    issue(CLEAR, 5'd0, 32'h0020_0020, 1'b0);
    wait_done(1'b0, 32'h0, 5000);
    check_eq("clr_cycles", 32'(cyc), 32'(1201 + SyncLat));
    check_eq("clr_first_wr", 32'(first_wr), 32'(1 + SyncLat));
    check_eq("clr_nwr", 32'(eng_wr - wr0), 1200);
    check_eq("clr_w0", mem[0], 32'h0020_0020);
    check_eq("clr_w1199", mem[1199], 32'h0020_0020);
    nbad = 0;
    for (int k = 0; k < 1200; k++) if (mem[k] !== 32'h0020_0020) nbad++;
    check_eq("clr_all", 32'(nbad), 0);

    // SCROLL: word k takes word k+40, bottom row gets fill 0.
    preload(32'h0);
    issue(SCROLL, 5'd0, 32'h0, 1'b0);
    wait_done(1'b0, 32'h0, 8000);
    check_eq("scr_cycles", 32'(cyc), 32'(3521 + SyncLat));
    check_eq("scr_nwr", 32'(eng_wr - wr0), 1200);
    check_eq("scr_w0", mem[0], 32'd40);
    check_eq("scr_w1159", mem[1159], 32'd1199);
    check_eq("scr_w1160", mem[1160], 32'd0);
    check_eq("scr_w1199", mem[1199], 32'd0);
    nbad = 0;
    for (int k = 0; k < 1160; k++) if (mem[k] !== 32'(k + 40)) nbad++;
    for (int k = 1160; k < 1200; k++) if (mem[k] !== 32'd0) nbad++;
    check_eq("scr_all", 32'(nbad), 0);

    // FILL_ROW 29 while the CPU reads word 5 (now 45) on every even cycle; engine writes on
    // the 40 odd cycles, 39 blocked cycles in between, so done lands in cycle 80.
    issue(FILL_ROW, 5'd29, 32'hDEAD_BEEF, 1'b1);
    wait_done(1'b1, 32'd45, 500);
    check_eq("row_cycles", 32'(cyc), 32'(80 + SyncLat));
    check_eq("row_nwr", 32'(eng_wr - wr0), 40);
    check_eq("row_w1160", mem[1160], 32'hDEAD_BEEF);
    check_eq("row_w1199", mem[1199], 32'hDEAD_BEEF);
    check_eq("row_w1159", mem[1159], 32'd1199);
    nbad = 0;
    for (int k = 1160; k < 1200; k++) if (mem[k] !== 32'hDEAD_BEEF) nbad++;
    check_eq("row_all", 32'(nbad), 0);

    // Out-of-range row and NOP: no writes, done one cycle after acceptance.
    issue(FILL_ROW, 5'd31, 32'h1234_5678, 1'b0);
    wait_done(1'b0, 32'h0, 50);
    check_eq("r31_cycles", 32'(cyc), 1);
    check_eq("r31_nwr", 32'(eng_wr - wr0), 0);
    issue(NOP, 5'd0, 32'h1234_5678, 1'b0);
    wait_done(1'b0, 32'h0, 50);
    check_eq("nop_cycles", 32'(cyc), 1);
    check_eq("nop_nwr", 32'(eng_wr - wr0), 0);
    check_eq("nop_w1160", mem[1160], 32'hDEAD_BEEF);

    // Reset in the 100th write cycle of a CLEAR: words 0..99 written, nothing after.
    preload(32'hA500_0000);
    issue(CLEAR, 5'd0, 32'h0020_0020, 1'b0);
    while (cyc < 100 + SyncLat) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) bus.cmd_valid = 1'b0;
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_done", 32'(bus.done), 0);
    check_eq("abort_ready", 32'(bus.cmd_ready), 1);
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.done) seen_done = 1'b1;
    end
    wr_seen = eng_wr - wr0;
    check_eq("abort_no_done", 32'(seen_done), 0);
    check_eq("abort_nwr", 32'(wr_seen), 100);
    check_eq("abort_w99", mem[99], 32'h0020_0020);
    check_eq("abort_w100", mem[100], 32'hA500_0064);
    nbad = 0;
    for (int k = 100; k < 1200; k++) if (mem[k] !== (32'hA500_0000 | 32'(k))) nbad++;
    check_eq("abort_rest", 32'(nbad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
